btn_debounce_edge: RTL and testbench

//  Conditions raw asynchronous push-button inputs for the synchronous core.
//  Per bit: 2-flop synchroniser, consecutive-sample debounce counter, registered

---
 rtl/btn_pkg.sv | 25 ++
 rtl/btn_debounce_edge_channel.sv | 130 +++++++++++++
 rtl/btn_debounce_edge.sv | 36 +++
 tb/tb_btn_debounce_edge.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types, default parameters and counter-width helpers for the
// push-button conditioning block (btn_debounce_edge).
package btn_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      CHANGING = 1'b1
   } db_state_t;

   localparam int DEF_WIDTH           = 5;
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 50000000;
   localparam int DEF_REPEAT_PERIOD   = 10000000;

   // Bits needed to hold any value 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of the auto-repeat down-counter, sized for the larger reload value.
   function automatic int rep_width(input int delay, input int period);
      return cnt_width((delay > period) ? delay : period);
   endfunction

endpackage

// File: rtl/btn_debounce_edge_channel.sv
// One button channel: 2-flop synchroniser, STABLE/CHANGING debounce FSM with
// consecutive-sample counter, registered level and press/release strobes.
// Optional auto-repeat of the press strobe when BTN_AUTOREPEAT_EN is defined.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  STABLE   | synchronised input agrees with the debounced level
//  CHANGING | input differs; cnt_q holds the number of differing samples
module debounce_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("debounce_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic           s1_q, s2_q;
   db_state_t      state_q;
   logic [CW-1:0]  cnt_q;
   logic           level_q, press_q, release_q;
   logic           diff, accept, rep_fire;

   // Bring the asynchronous pin into the clock domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_i;
         s2_q <= s1_q;
      end
   end

   // cnt_q counts differing samples already seen, so the current differing
   // sample is the DEBOUNCE_CYCLES-th one when cnt_q reaches DEBOUNCE_CYCLES-1.
   // This keeps the counter below its maximum, so it can never wrap.
   assign diff   = s2_q ^ level_q;
   assign accept = diff && (((state_q == STABLE) && (DEBOUNCE_CYCLES == 1)) ||
                            ((state_q == CHANGING) && (cnt_q == CNT_LAST)));

   // Debounce FSM with registered level and one-cycle strobes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= STABLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= (accept & s2_q) | rep_fire;
         release_q <= accept & ~s2_q;
         if (accept) begin
            level_q <= s2_q;
            state_q <= STABLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               STABLE: begin
                  if (diff) begin
                     state_q <= CHANGING;
                     cnt_q   <= CNT_ONE;
                  end else begin
                     cnt_q   <= '0;
                  end
               end
               CHANGING: begin
                  if (!diff) begin
                     state_q <= STABLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= STABLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int             RW        = rep_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [RW-1:0]  REP_ONE   = RW'(1);
   localparam logic [RW-1:0]  REP_FIRST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  REP_NEXT  = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_q;

   // A release accepted on this edge wins over a repeat due on the same edge.
   assign rep_fire = level_q & ~accept & (rep_q == '0);

   // Hold down-counter: loaded on the press, reloaded at each repeat, cleared
   // whenever the button is not held.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rep_q <= '0;
      end else if (accept & s2_q) begin
         rep_q <= REP_FIRST;
      end else if (level_q & ~accept) begin
         rep_q <= (rep_q == '0) ? REP_NEXT : rep_q - REP_ONE;
      end else begin
         rep_q <= '0;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_edge.sv
// Push-button conditioning: WIDTH independent debounce channels between the
// board pins and the first clocked register stage.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat press strobes).
module btn_debounce_edge
   import btn_pkg::*;
#(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release
);

   // One channel per button bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk_i     (clk),
         .rst_ni    (rst_n),
         .btn_i     (btn_in[i]),
         .level_o   (btn_level[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Scoreboard bench for btn_debounce_edge (WIDTH=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3). Stimulus pushes hand-computed output
// events (edge number, level, press, release); the monitor pops one whenever
// the outputs show an event (level change or any strobe).
module tb_btn_debounce_edge;

   localparam int W       = 2;
   localparam int END_CYC = 170;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] btn_in = '0;
   logic [W-1:0] btn_level, btn_press, btn_release;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      int           c;
      logic [W-1:0] lvl;
      logic [W-1:0] prs;
      logic [W-1:0] rel;
   } ev_t;

   ev_t exp_q[$];

   btn_debounce_edge #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_ev(input int c, input logic [W-1:0] l,
                            input logic [W-1:0] p, input logic [W-1:0] r);
      ev_t e;
      e.c = c; e.lvl = l; e.prs = p; e.rel = r;
      exp_q.push_back(e);
   endtask

   // Monitor: sole owner of the counters.
   logic [W-1:0] prev_lvl = '0;
   always @(negedge clk or negedge rst_n) begin
      ev_t e;
      #1;
      if (!rst_n) begin
         n_vec++;
         if ({btn_level, btn_press, btn_release} !== '0) begin
            n_err++;
            $display("FAIL reset_zero cyc=%0d got lvl=%b prs=%b rel=%b want all 0",
                     cyc, btn_level, btn_press, btn_release);
         end
      end
      if (btn_level !== prev_lvl || btn_press !== '0 || btn_release !== '0) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event cyc=%0d got lvl=%b prs=%b rel=%b want no event",
                     cyc, btn_level, btn_press, btn_release);
         end else begin
            e = exp_q.pop_front();
            if (e.c != cyc || e.lvl !== btn_level || e.prs !== btn_press || e.rel !== btn_release) begin
               n_err++;
               $display("FAIL event got cyc=%0d lvl=%b prs=%b rel=%b want cyc=%0d lvl=%b prs=%b rel=%b",
                        cyc, btn_level, btn_press, btn_release, e.c, e.lvl, e.prs, e.rel);
            end
         end
      end
      prev_lvl = btn_level;
      if (clk == 1'b0 && cyc == END_CYC) begin
         n_vec++;
         if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events got %0d pending (first due cyc=%0d) want 0",
                     exp_q.size(), exp_q[0].c);
         end
      end
   end

   initial begin
      wait_to(2);
      rst_n = 1'b1;

      // Clean press on bit 0, then release.
      wait_to(10); btn_in = 2'b01;
      expect_ev(16, 2'b01, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
      expect_ev(24, 2'b01, 2'b01, 2'b00);
`endif
      wait_to(20); btn_in = 2'b00;
      expect_ev(26, 2'b00, 2'b00, 2'b01);

      // Glitch of 3 samples is rejected, then a real 10-cycle press.
      wait_to(30); btn_in = 2'b01;
      wait_to(33); btn_in = 2'b00;
      wait_to(40); btn_in = 2'b01;
      expect_ev(46, 2'b01, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
      expect_ev(54, 2'b01, 2'b01, 2'b00);
`endif
      wait_to(50); btn_in = 2'b00;
      expect_ev(56, 2'b00, 2'b00, 2'b01);

      // Simultaneous press and release on both bits.
      wait_to(60); btn_in = 2'b11;
      expect_ev(66, 2'b11, 2'b11, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
      expect_ev(74, 2'b11, 2'b11, 2'b00);
`endif
      wait_to(70); btn_in = 2'b00;
      expect_ev(76, 2'b00, 2'b00, 2'b11);

      // Long hold on bit 0 (auto-repeat when enabled).
      wait_to(80); btn_in = 2'b01;
      expect_ev(86, 2'b01, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
      for (int c = 94; c <= 115; c += 3) expect_ev(c, 2'b01, 2'b01, 2'b00);
`endif
      wait_to(110); btn_in = 2'b00;
      expect_ev(116, 2'b00, 2'b00, 2'b01);

      // Reset mid-count on bit 1 while bit 0 is held high.
      wait_to(120); btn_in = 2'b01;
      expect_ev(126, 2'b01, 2'b01, 2'b00);
      wait_to(128); btn_in = 2'b11;
      wait_to(132);
      expect_ev(132, 2'b00, 2'b00, 2'b00);
      rst_n = 1'b0;
      wait_to(134); rst_n = 1'b1;
      expect_ev(140, 2'b11, 2'b11, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
      expect_ev(148, 2'b11, 2'b11, 2'b00);
      expect_ev(151, 2'b11, 2'b11, 2'b00);
      expect_ev(154, 2'b11, 2'b11, 2'b00);
`endif
      wait_to(150); btn_in = 2'b00;
      expect_ev(156, 2'b00, 2'b00, 2'b11);

      wait_to(END_CYC + 2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
